alu_scheduler: RTL
==================

# alu_scheduler

Sequences the shared 8-bit ALU of the simplex8 datapath and arbitrates it between two requesters (A = CPU control path, B = debug/test front end driving the switch/seven-segment harness). Each requester submits one operation (opcode, ACC and REG operands, set-flags request) over a valid/ready handshake. The block drives the ALU's one-hot control strobes and operands, captures RESULT and the registered FLAGS, and returns them to the winning requester over a response handshake. Requesters are granted in round-robin order.

## Interface
- FLAG_W, 4, width of the ALU FLAGS bus
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  reset, synchronous, active-low
- a_req_valid / b_req_valid  in  1  request present
- a_req_ready / b_req_ready  out  1  request accepted this cycle when valid&ready
- a_req_op / b_req_op  in  3  opcode: 0 ADD, 1 SUB, 2 SHIFT, 3 OR, 4 AND, 5–7 illegal
- a_req_acc / b_req_acc  in  8  ACC operand
- a_req_reg / b_req_reg  in  8  REG operand
- a_req_setflags / b_req_setflags  in  1  update ALU FLAGS for this op
- a_rsp_valid / b_rsp_valid  out  1  response held until ready
- a_rsp_ready / b_rsp_ready  in  1  response consumed
- rsp_result  out  8  captured RESULT (shared by both response ports)
- rsp_flags  out  FLAG_W  captured FLAGS
- rsp_err  out  1  illegal opcode
- alu_add, alu_sub, alu_shift, alu_or, alu_and  out  1  ALU strobes, at most one high
- alu_setflags  out  1  ALU SetFlags
- alu_acc, alu_reg  out  8  ALU operands
- alu_result  in  8  ALU RESULT, combinational from operands/strobes
- alu_flags  in  FLAG_W  ALU FLAGS, registered in the ALU on CLK when SetFlags high

## Operation
- States: IDLE, EXEC, SETTLE, RESP.
- IDLE: req_ready is high only for the port the arbiter picks. If only one port is valid, that port is picked. If both are valid, the port named by the priority pointer is picked. Handshake latches op, acc, reg, setflags, and owner; next state is EXEC. The pointer moves to the non-owner on every grant.
- EXEC (1 cycle): alu_acc/alu_reg = latched operands. Exactly one strobe is high per the opcode. alu_setflags = latched setflags. alu_result is captured into rsp_result at the end of the cycle. Next state is SETTLE.
- SETTLE (1 cycle): all strobes and alu_setflags are low, and operands are held. alu_flags (now updated) is captured into rsp_flags. Next state is RESP.
- RESP: the owner's rsp_valid is high; the other port's is 0. rsp_result, rsp_flags, and rsp_err are stable. On rsp_ready, return to IDLE.
- Illegal opcode: EXEC drives no strobe and alu_setflags = 0. rsp_result = 0, rsp_flags = ALU's current FLAGS, rsp_err = 1. Same latency as a legal op.
- A non-owner's request waits in IDLE. req_ready = 0 in all states except IDLE.
- When no operation is active, strobes and alu_setflags are 0.

## Timing
- Reset (RST_N low at an edge):
  - state = IDLE, pointer = A.
  - All req_ready, rsp_valid, strobes, and alu_setflags = 0.
  - alu_acc, alu_reg, rsp_result, rsp_flags, and rsp_err = 0.
- Reset mid-operation aborts the operation with no response. A FLAGS update already issued in EXEC is not undone.
- Latency: request handshake at cycle n, EXEC at n+1, SETTLE at n+2, rsp_valid first high at n+3.
- rsp_ready is sampled only in RESP. If it is already high when RESP is entered, the response completes in one cycle.
- Throughput: one op per 4 cycles at best (IDLE handshake, EXEC, SETTLE, RESP).
- Arithmetic wrap, carry, and shift semantics belong to the ALU. This block passes 8-bit values unchanged.

## Structure
- Shared include alu_ops.vh holds the opcode constants (OP_ADD..OP_AND, OP_W = 3) and the state encodings. The CPU control path and the test harness use the same file.
- One sub-module: rr_arb2 (2-way round-robin arbiter: valids in, one-hot grant out, pointer advanced on an accept pulse).
- The opcode-to-strobe decode is a combinational function inside alu_scheduler.

## Test plan
- Single op: A requests ADD, acc = 8'h05, reg = 8'h03, setflags = 1.
  - Expect alu_add high only in cycle n+1.
  - Expect a_rsp_valid at n+3 with rsp_result = 8'h08 and rsp_flags equal to the ALU model.
- Contention: A and B are both valid continuously from reset.
  - Expect grants in order A, B, A, B.
  - Each response goes to the correct port; the other port's rsp_valid stays 0.
- Backpressure: B's SUB 8'h10 − 8'h01 with b_rsp_ready held low for 5 cycles.
  - rsp_valid and rsp_result = 8'h0F stay stable.
  - A's pending request stays unaccepted until the cycle after B's handshake.
- Illegal op: A sends opcode 7.
  - No strobe and no setflags in EXEC.
  - rsp_err = 1 and rsp_result = 0 at n+3.
- Setflags off: OR 8'hF0 | 8'h0F with setflags = 0.
  - rsp_result = 8'hFF; ALU FLAGS unchanged from the previous op.
- Reset in SETTLE: RST_N is low for one edge.
  - All outputs return to reset values the next cycle, and no rsp_valid is issued.
  - The next grant goes to A.

Source files
------------

// File: rtl/alu_scheduler_pkg.sv
// Opcode constants, FSM states and strobe bundle for the
// simplex8 ALU scheduler, shared with control path and harness.
package alu_scheduler_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
   localparam logic [OP_W-1:0] OP_SUB   = 3'd1;
   localparam logic [OP_W-1:0] OP_SHIFT = 3'd2;
   localparam logic [OP_W-1:0] OP_OR    = 3'd3;
   localparam logic [OP_W-1:0] OP_AND   = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_SETTLE,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic add_s;
      logic sub_s;
      logic shift_s;
      logic or_s;
      logic and_s;
   } strobe_t;

endpackage

// File: rtl/alu_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from valids,
// pointer moves to the non-granted port on each accept.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic [1:0] grant
);

   logic ptr;

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // ptr = 0 favours A, 1 favours B
   always_ff @(posedge clk) begin
      if (!rst_n)
         ptr <= 1'b0;
      else if (accept)
         ptr <= grant[0];
   end

endmodule

// File: rtl/alu_scheduler.sv
// Sequences the shared 8-bit ALU and arbitrates it between
// requester A (CPU) and B (debug front end).
module alu_scheduler
   import alu_scheduler_pkg::*;
#(
   parameter int FLAG_W = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic [2:0]        a_req_op,
   input  logic [7:0]        a_req_acc,
   input  logic [7:0]        a_req_reg,
   input  logic              a_req_setflags,
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic [2:0]        b_req_op,
   input  logic [7:0]        b_req_acc,
   input  logic [7:0]        b_req_reg,
   input  logic              b_req_setflags,
   output logic              a_rsp_valid,
   input  logic              a_rsp_ready,
   output logic              b_rsp_valid,
   input  logic              b_rsp_ready,
   output logic [7:0]        rsp_result,
   output logic [FLAG_W-1:0] rsp_flags,
   output logic              rsp_err,
   output logic              alu_add,
   output logic              alu_sub,
   output logic              alu_shift,
   output logic              alu_or,
   output logic              alu_and,
   output logic              alu_setflags,
   output logic [7:0]        alu_acc,
   output logic [7:0]        alu_reg,
   input  logic [7:0]        alu_result,
   input  logic [FLAG_W-1:0] alu_flags
);

   function automatic strobe_t decode_op(
      input logic [OP_W-1:0] op
   );
      strobe_t s;
      s = '0;
      case (op)
         OP_ADD:   s.add_s   = 1'b1;
         OP_SUB:   s.sub_s   = 1'b1;
         OP_SHIFT: s.shift_s = 1'b1;
         OP_OR:    s.or_s    = 1'b1;
         OP_AND:   s.and_s   = 1'b1;
         default:  s = '0;
      endcase
      return s;
   endfunction

   state_e          state;
   strobe_t         stb;
   logic            owner;
   logic            err_q;
   logic [1:0]      grant;
   logic            accept;
   logic            sel_b;
   logic [OP_W-1:0] sel_op;
   logic [7:0]      sel_acc;
   logic [7:0]      sel_reg;
   logic            sel_sf;
   strobe_t         sel_stb;
   logic            sel_legal;
   logic            own_ready;

   rr_arb2 u_arb (
      .clk    (CLK),
      .rst_n  (RST_N),
      .valid  ({b_req_valid, a_req_valid}),
      .accept (accept),
      .grant  (grant)
   );

   // ready is held low while reset is asserted
   assign a_req_ready = RST_N && (state == ST_IDLE)
                        && grant[0];
   assign b_req_ready = RST_N && (state == ST_IDLE)
                        && grant[1];
   assign accept = (a_req_valid && a_req_ready)
                   || (b_req_valid && b_req_ready);

   assign sel_b     = grant[1];
   assign sel_op    = sel_b ? b_req_op : a_req_op;
   assign sel_acc   = sel_b ? b_req_acc : a_req_acc;
   assign sel_reg   = sel_b ? b_req_reg : a_req_reg;
   assign sel_sf    = sel_b ? b_req_setflags
                            : a_req_setflags;
   assign sel_stb   = decode_op(sel_op);
   assign sel_legal = |sel_stb;
   assign own_ready = owner ? b_rsp_ready : a_rsp_ready;

   assign alu_add   = stb.add_s;
   assign alu_sub   = stb.sub_s;
   assign alu_shift = stb.shift_s;
   assign alu_or    = stb.or_s;
   assign alu_and   = stb.and_s;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state        <= ST_IDLE;
         stb          <= '0;
         owner        <= 1'b0;
         err_q        <= 1'b0;
         alu_setflags <= 1'b0;
         alu_acc      <= '0;
         alu_reg      <= '0;
         rsp_result   <= '0;
         rsp_flags    <= '0;
         rsp_err      <= 1'b0;
         a_rsp_valid  <= 1'b0;
         b_rsp_valid  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  owner        <= sel_b;
                  alu_acc      <= sel_acc;
                  alu_reg      <= sel_reg;
                  stb          <= sel_stb;
                  alu_setflags <= sel_sf && sel_legal;
                  err_q        <= !sel_legal;
                  state        <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_result   <= err_q ? 8'h00 : alu_result;
               rsp_err      <= err_q;
               stb          <= '0;
               alu_setflags <= 1'b0;
               state        <= ST_SETTLE;
            end
            ST_SETTLE: begin
               rsp_flags   <= alu_flags;
               a_rsp_valid <= !owner;
               b_rsp_valid <= owner;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (own_ready) begin
                  a_rsp_valid <= 1'b0;
                  b_rsp_valid <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
